// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs one CNN inference layer by layer over the engines.
// Ports: clk/reset, load_done[NUM_LAYERS:0] region-loaded pulses, clear abort,
//   result_ack host read, layer_done/layer_start engine handshake, buf_sel act
//   buffer used as layer input, cur_layer, busy, result_valid, error status.
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS  = 4,
    parameter int TIMEOUT_W   = 24,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LAYERS:0]   load_done,
    input  logic                  clear,
    input  logic                  result_ack,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  buf_sel,
    output logic [2:0]            cur_layer,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  error
);

    localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_SWAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state;
    logic [NUM_LAYERS:0]    mask;
    logic [NUM_LAYERS:0]    mask_set;
    logic [KW-1:0]          k;
    logic [TIMEOUT_W-1:0]   wd;

    assign mask_set = mask | load_done;

    always_ff @(posedge clk) begin
        // clear behaves exactly like reset, so a coincident load is dropped
        if (reset || clear) begin
            state        <= S_IDLE;
            mask         <= '0;
            k            <= '0;
            wd           <= '0;
            layer_start  <= '0;
            buf_sel      <= 1'b0;
            cur_layer    <= 3'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            layer_start <= '0;
            if (state != S_ERR)
                mask <= mask_set;
            unique case (state)
                S_IDLE: begin
                    if (&mask) begin
                        // input image is consumed; a same-cycle reload of it survives
                        mask        <= {mask_set[NUM_LAYERS:1], load_done[0]};
                        state       <= S_START;
                        k           <= '0;
                        layer_start <= NUM_LAYERS'(1);
                        cur_layer   <= 3'd0;
                        busy        <= 1'b1;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                    wd    <= '0;
                end
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    // done beats watchdog expiry on the same cycle
                    if (layer_done[k]) begin
                        state     <= S_SWAP;
                        cur_layer <= 3'd0;
                    end else if (wd == WD_LAST) begin
                        state     <= S_ERR;
                        cur_layer <= 3'd0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                    end
                end
                S_SWAP: begin
                    buf_sel <= ~buf_sel;
                    if (k == K_LAST) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end else begin
                        state       <= S_START;
                        k           <= k + 1'b1;
                        layer_start <= NUM_LAYERS'(1) << (k + 1'b1);
                        cur_layer   <= 3'(k + 1'b1);
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        state        <= S_IDLE;
                        result_valid <= 1'b0;
                        buf_sel      <= 1'b0;
                    end
                end
                S_ERR: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed bench for cnn_layer_sequencer.
// Short watchdog (16 cycles) so timeout paths are reachable.
module tb_cnn_layer_sequencer;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NL:0]   load_done = '0;
    logic          clear = 1'b0;
    logic          result_ack = 1'b0;
    logic [NL-1:0] layer_done = '0;
    logic [NL-1:0] layer_start;
    logic          buf_sel;
    logic [2:0]    cur_layer;
    logic          busy;
    logic          result_valid;
    logic          error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NUM_LAYERS (NL),
        .TIMEOUT_W  (24),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_done   (load_done),
        .clear       (clear),
        .result_ack  (result_ack),
        .layer_done  (layer_done),
        .layer_start (layer_start),
        .buf_sel     (buf_sel),
        .cur_layer   (cur_layer),
        .busy        (busy),
        .result_valid(result_valid),
        .error       (error)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ls,
                           input logic bs, input logic [2:0] cl,
                           input logic bz, input logic rv, input logic er);
        chk({tag, ".start"}, 32'(layer_start), 32'(ls));
        chk({tag, ".buf"},   32'(buf_sel),     32'(bs));
        chk({tag, ".cur"},   32'(cur_layer),   32'(cl));
        chk({tag, ".busy"},  32'(busy),        32'(bz));
        chk({tag, ".rv"},    32'(result_valid), 32'(rv));
        chk({tag, ".err"},   32'(error),       32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int i);
        load_done = (NL+1)'(1) << i;
        step();
        load_done = '0;
    endtask

    // entered while observing layer k's START cycle; leaves at the next
    // START (or DONE) cycle; done arrives 3 cycles after the start pulse
    task automatic do_layer(input int k);
        step();
        chk_out($sformatf("L%0d.wait", k), 4'd0, 1'(k % 2), 3'(k), 1, 0, 0);
        layer_done = NL'(1) << ((k + 1) % NL);
        step();
        layer_done = '0;
        step();
        layer_done = NL'(1) << k;
        step();
        layer_done = '0;
        chk_out($sformatf("L%0d.swap", k), 4'd0, 1'(k % 2), 3'd0, 1, 0, 0);
        step();
        if (k < NL - 1)
            chk_out($sformatf("L%0d.start", k + 1), 4'(1 << (k + 1)),
                    1'((k + 1) % 2), 3'(k + 1), 1, 0, 0);
        else
            chk_out("done", 4'd0, 1'b0, 3'd0, 0, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;

        step();
        step();
        reset = 1'b0;
        chk_out("rst", 4'd0, 0, 3'd0, 0, 0, 0);

        for (int i = 0; i <= NL; i++) pulse_load(i);
        chk("t1.nostart_yet", 32'(layer_start), 32'd0);
        step();
        chk_out("t1.start0", 4'b0001, 0, 3'd0, 1, 0, 0);

        for (int k = 0; k < NL; k++) do_layer(k);
        step();
        chk_out("t2.hold", 4'd0, 0, 3'd0, 0, 1, 0);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk_out("t2.ack", 4'd0, 0, 3'd0, 0, 0, 0);

        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | busy | (|layer_start);
        end
        chk("t3.no_input_idle", 32'(seen), 32'd0);
        pulse_load(0);
        chk("t3.not_yet", 32'(layer_start), 32'd0);
        step();
        chk_out("t3.start0", 4'b0001, 0, 3'd0, 1, 0, 0);

        do_layer(0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) layer_done = 4'b0100;
            step();
            layer_done = '0;
        end
        chk_out("t4.wait16", 4'd0, 1, 3'd1, 1, 0, 0);
        step();
        chk_out("t4.err", 4'd0, 1, 3'd0, 0, 0, 1);
        layer_done = 4'b0010;
        step();
        layer_done = '0;
        step();
        chk_out("t4.err_stuck", 4'd0, 1, 3'd0, 0, 0, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_out("t4.clear", 4'd0, 0, 3'd0, 0, 0, 0);

        for (int i = 0; i <= NL; i++) pulse_load(i);
        step();
        chk_out("t5.start0", 4'b0001, 0, 3'd0, 1, 0, 0);
        do_layer(0);
        do_layer(1);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_out("t5.clear", 4'd0, 0, 3'd0, 0, 0, 0);
        pulse_load(0);
        step();
        step();
        step();
        chk_out("t5.weights_gone", 4'd0, 0, 3'd0, 0, 0, 0);
        for (int i = 1; i <= NL; i++) pulse_load(i);
        step();
        chk_out("t5.restart", 4'b0001, 0, 3'd0, 1, 0, 0);

        for (int i = 0; i < 16; i++) step();
        layer_done = 4'b0001;
        step();
        layer_done = '0;
        chk_out("t6.race_swap", 4'd0, 0, 3'd0, 1, 0, 0);
        step();
        chk_out("t6.start1", 4'b0010, 1, 3'd1, 1, 0, 0);
        clear = 1'b1;
        load_done = 5'b00001;
        step();
        clear = 1'b0;
        load_done = '0;
        chk_out("t6.clear", 4'd0, 0, 3'd0, 0, 0, 0);
        for (int i = 1; i <= NL; i++) pulse_load(i);
        step();
        step();
        chk_out("t6.load0_dropped", 4'd0, 0, 3'd0, 0, 0, 0);
        pulse_load(0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_out("t6.start_killed", 4'd0, 0, 3'd0, 0, 0, 0);
        step();
        step();
        chk_out("t6.stay_idle", 4'd0, 0, 3'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
